// File: rtl/spi_xfer_scheduler.sv
// Two-client byte-transfer scheduler for the SPI master register port.
// Each granted request runs TX write, STATUS polling, RX read, then a one-cycle response.
module spi_xfer_scheduler #(
   parameter int unsigned DW          = 8,
   parameter logic [2:0]  ADDR_TX     = 3'd1,
   parameter logic [2:0]  ADDR_RX     = 3'd0,
   parameter logic [2:0]  ADDR_STATUS = 3'd2,
   parameter int unsigned DONE_BIT    = 0,
   parameter int unsigned POLL_MAX    = 64
) (
   input  logic          I_CLK,
   input  logic          I_RESETN,
   input  logic          req0_valid,
   input  logic [DW-1:0] req0_data,
   output logic          req0_ready,
   output logic          rsp0_valid,
   output logic [DW-1:0] rsp0_data,
   output logic          rsp0_err,
   input  logic          req1_valid,
   input  logic [DW-1:0] req1_data,
   output logic          req1_ready,
   output logic          rsp1_valid,
   output logic [DW-1:0] rsp1_data,
   output logic          rsp1_err,
   output logic          O_TX_EN,
   output logic [2:0]    O_WADDR,
   output logic [DW-1:0] O_WDATA,
   output logic          O_RX_EN,
   output logic [2:0]    O_RADDR,
   input  logic [DW-1:0] I_RDATA,
   output logic          busy
);

   localparam int unsigned   PCW       = $clog2(POLL_MAX + 1);
   localparam logic [PCW-1:0] POLL_LAST = PCW'(POLL_MAX);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR,
      ST_POLL,
      ST_CHK,
      ST_RD,
      ST_CAP,
      ST_DONE
   } state_t;

   state_t          state;
   logic            last_grant;
   logic            grant_id;
   logic [PCW-1:0]  poll_cnt;
   logic            win0;
   logic            win1;
   logic            accept;

   // Handshake: a request transfers on any cycle where reqN_valid and reqN_ready
   // are both high; ready is only offered in IDLE, to the arbitration winner.
   always_comb begin
      win0       = req0_valid & (~req1_valid | last_grant);
      win1       = req1_valid & (~req0_valid | ~last_grant);
      req0_ready = (state == ST_IDLE) & ~I_RESETN & win0;
      req1_ready = (state == ST_IDLE) & ~I_RESETN & win1;
      accept     = req0_ready | req1_ready;
   end

   always_ff @(posedge I_CLK) begin
      if (I_RESETN) begin
         state      <= ST_IDLE;
         last_grant <= 1'b1;
         grant_id   <= 1'b0;
         poll_cnt   <= '0;
         busy       <= 1'b0;
         O_TX_EN    <= 1'b0;
         O_WADDR    <= '0;
         O_WDATA    <= '0;
         O_RX_EN    <= 1'b0;
         O_RADDR    <= '0;
         rsp0_valid <= 1'b0;
         rsp0_data  <= '0;
         rsp0_err   <= 1'b0;
         rsp1_valid <= 1'b0;
         rsp1_data  <= '0;
         rsp1_err   <= 1'b0;
      end else begin
         // Strobes and response fields default low so each lasts exactly one cycle.
         O_TX_EN    <= 1'b0;
         O_WADDR    <= '0;
         O_WDATA    <= '0;
         O_RX_EN    <= 1'b0;
         O_RADDR    <= '0;
         rsp0_valid <= 1'b0;
         rsp0_data  <= '0;
         rsp0_err   <= 1'b0;
         rsp1_valid <= 1'b0;
         rsp1_data  <= '0;
         rsp1_err   <= 1'b0;

         case (state)
            ST_IDLE: begin
               if (accept) begin
                  grant_id   <= req1_ready;
                  last_grant <= req1_ready;
                  O_TX_EN    <= 1'b1;
                  O_WADDR    <= ADDR_TX;
                  O_WDATA    <= req1_ready ? req1_data : req0_data;
                  busy       <= 1'b1;
                  state      <= ST_WR;
               end
            end

            ST_WR: begin
               poll_cnt <= '0;
               O_RX_EN  <= 1'b1;
               O_RADDR  <= ADDR_STATUS;
               state    <= ST_POLL;
            end

            ST_POLL: begin
               if (poll_cnt != POLL_LAST) begin
                  poll_cnt <= poll_cnt + 1'b1;
               end
               state <= ST_CHK;
            end

            ST_CHK: begin
               if (I_RDATA[DONE_BIT]) begin
                  O_RX_EN <= 1'b1;
                  O_RADDR <= ADDR_RX;
                  state   <= ST_RD;
               end else if (poll_cnt == POLL_LAST) begin
                  if (grant_id) begin
                     rsp1_valid <= 1'b1;
                     rsp1_err   <= 1'b1;
                  end else begin
                     rsp0_valid <= 1'b1;
                     rsp0_err   <= 1'b1;
                  end
                  state <= ST_DONE;
               end else begin
                  O_RX_EN <= 1'b1;
                  O_RADDR <= ADDR_STATUS;
                  state   <= ST_POLL;
               end
            end

            ST_RD: begin
               state <= ST_CAP;
            end

            ST_CAP: begin
               // I_RDATA carries the RX register one cycle after the RD strobe.
               if (grant_id) begin
                  rsp1_valid <= 1'b1;
                  rsp1_data  <= I_RDATA;
               end else begin
                  rsp0_valid <= 1'b1;
                  rsp0_data  <= I_RDATA;
               end
               state <= ST_DONE;
            end

            ST_DONE: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
            end

            default: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spi_xfer_scheduler.sv
// Bench for spi_xfer_scheduler: directed scenarios plus randomized transfers against
// a transaction-level model of arbitration, latency and register-port traffic.
module tb_spi_xfer_scheduler;

   localparam int DW = 8;
   localparam int PM = 4;

   logic          I_CLK = 1'b0;
   logic          I_RESETN = 1'b1;
   logic          req0_valid = 1'b0;
   logic [DW-1:0] req0_data = '0;
   logic          req1_valid = 1'b0;
   logic [DW-1:0] req1_data = '0;
   logic [DW-1:0] I_RDATA = '0;
   logic          req0_ready, req1_ready;
   logic          rsp0_valid, rsp1_valid, rsp0_err, rsp1_err;
   logic [DW-1:0] rsp0_data, rsp1_data, O_WDATA;
   logic          O_TX_EN, O_RX_EN, busy;
   logic [2:0]    O_WADDR, O_RADDR;

   spi_xfer_scheduler #(
      .DW(DW), .ADDR_TX(3'd1), .ADDR_RX(3'd0), .ADDR_STATUS(3'd2),
      .DONE_BIT(0), .POLL_MAX(PM)
   ) dut (
      .I_CLK(I_CLK), .I_RESETN(I_RESETN),
      .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
      .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data), .rsp0_err(rsp0_err),
      .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
      .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data), .rsp1_err(rsp1_err),
      .O_TX_EN(O_TX_EN), .O_WADDR(O_WADDR), .O_WDATA(O_WDATA),
      .O_RX_EN(O_RX_EN), .O_RADDR(O_RADDR), .I_RDATA(I_RDATA),
      .busy(busy)
   );

   // clock / reset
   always #5 I_CLK = ~I_CLK;

   int            cyc = 0;
   always @(posedge I_CLK) cyc <= cyc + 1;

   int            n_cmp = 0;
   int            n_err = 0;
   int            tx_cnt = 0, tx_cyc = 0, stat_reads = 0, rx_reads = 0;
   int            busy_cnt = 0, rsp_cnt = 0, viol = 0;
   logic [2:0]    tx_addr = '0;
   logic [DW-1:0] tx_data = '0;
   int            ip_done_after = 0;
   logic [DW-1:0] ip_rx = '0;

   logic          model_last = 1'b1;
   logic [1:0]    pending = 2'b00;
   logic [DW-1:0] hold0 = '0, hold1 = '0;
   logic [DW-1:0] exp_q[$];

   // SPI IP register model: answers a read strobe on the following cycle only.
   always begin : ip_model
      logic       en;
      logic [2:0] a;
      @(negedge I_CLK);
      en = O_RX_EN;
      a  = O_RADDR;
      @(posedge I_CLK);
      #1;
      if (en && a == 3'd2) begin
         stat_reads++;
         I_RDATA = {7'($urandom), (ip_done_after != 0 && stat_reads >= ip_done_after)};
      end else if (en && a == 3'd0) begin
         rx_reads++;
         I_RDATA = ip_rx;
      end else begin
         I_RDATA = 8'($urandom);
      end
   end

   // Port monitor: register-port writes, idle-value rules, response pulses, busy time.
   always @(negedge I_CLK) begin
      if (O_TX_EN) begin
         tx_cnt++;
         tx_cyc  = cyc;
         tx_addr = O_WADDR;
         tx_data = O_WDATA;
      end else if (O_WADDR != '0 || O_WDATA != '0) begin
         viol++;
      end
      if (!O_RX_EN && O_RADDR != '0) viol++;
      if (!rsp0_valid && (rsp0_data != '0 || rsp0_err)) viol++;
      if (!rsp1_valid && (rsp1_data != '0 || rsp1_err)) viol++;
      if (rsp0_valid || rsp1_valid) rsp_cnt++;
      if (busy) busy_cnt++;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: run did not reach its summary in time");
      $fatal(1, "watchdog expired");
   end

   // driver tasks
   task automatic step();
      @(negedge I_CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] all_outs();
      return {25'd0, req0_ready, req1_ready, rsp0_valid, rsp0_data, rsp0_err,
              rsp1_valid, rsp1_data, rsp1_err, O_TX_EN, O_WADDR, O_WDATA,
              O_RX_EN, O_RADDR, busy};
   endfunction

   task automatic clear_counts();
      tx_cnt = 0; stat_reads = 0; rx_reads = 0; busy_cnt = 0; rsp_cnt = 0;
   endtask

   // One transfer: mask gives which requesters are valid; a losing requester stays valid.
   task automatic run_one(input logic [1:0] mask, input int done_after, input logic [DW-1:0] rx);
      int            t, r, polls, off;
      logic          win, done, got;
      logic [DW-1:0] tx_exp, rx_exp;
      done   = (done_after >= 1 && done_after <= PM);
      polls  = done ? done_after : PM;
      off    = done ? 2 * done_after + 4 : 2 * PM + 2;
      win    = (mask == 2'b11) ? ~model_last : mask[1];
      tx_exp = win ? hold1 : hold0;
      exp_q.push_back(done ? rx : 8'h00);
      ip_done_after = done_after;
      ip_rx = rx;
      clear_counts();
      req0_data  = hold0;
      req1_data  = hold1;
      req0_valid = mask[0];
      req1_valid = mask[1];
      #1;
      chk("ready_grant", 64'({req1_ready, req0_ready}), 64'(win ? 2'b10 : 2'b01));
      t = cyc;
      model_last = win;
      pending = mask & ~(win ? 2'b10 : 2'b01);
      step();
      if (win) req1_valid = 1'b0; else req0_valid = 1'b0;
      #1;
      chk("ready_while_busy", 64'({req1_ready, req0_ready}), 64'd0);
      got = 1'b0;
      for (int i = 0; i < 2 * PM + 20; i++) begin
         if (rsp0_valid || rsp1_valid) begin
            got = 1'b1;
            break;
         end
         step();
      end
      chk("rsp_seen", 64'(got), 64'd1);
      rx_exp = exp_q.pop_front();
      if (got) begin
         r = cyc;
         chk("rsp_latency", 64'(r - t), 64'(off));
         chk("rsp_target", 64'({rsp1_valid, rsp0_valid}), 64'(win ? 2'b10 : 2'b01));
         chk("rsp_data", 64'(win ? rsp1_data : rsp0_data), 64'(rx_exp));
         chk("rsp_err", 64'(win ? rsp1_err : rsp0_err), 64'(!done));
         chk("tx_count", 64'(tx_cnt), 64'd1);
         chk("tx_cycle", 64'(tx_cyc - t), 64'd1);
         chk("tx_addr", 64'(tx_addr), 64'd1);
         chk("tx_data", 64'(tx_data), 64'(tx_exp));
         chk("status_reads", 64'(stat_reads), 64'(polls));
         chk("rx_reads", 64'(rx_reads), 64'(done ? 1 : 0));
         chk("busy_cycles", 64'(busy_cnt), 64'(off));
         step();
         chk("idle_after", 64'({busy, rsp1_valid, rsp0_valid}), 64'd0);
      end
   endtask

   initial begin : stimulus
      logic [1:0] m;
      int         t;

      // reset state
      I_RESETN = 1'b1;
      step(); step(); step();
      chk("reset_outputs", all_outs(), 64'd0);
      I_RESETN = 1'b0;
      step();

      // simultaneous requests after reset: req0 first, req1 the cycle after rsp0
      hold0 = 8'h11;
      hold1 = 8'h22;
      run_one(2'b11, 1, 8'h5A);
      run_one(pending, 2, 8'hC3);

      // single request, done on first poll
      hold0 = 8'hA5;
      run_one(2'b01, 1, 8'h3C);

      // STATUS never done: timeout with error and zero data
      hold0 = 8'h96;
      run_one(2'b01, 0, 8'hFF);

      // done on third poll
      hold1 = 8'h4E;
      run_one(2'b10, 3, 8'hB7);

      // reset pulse while checking STATUS
      clear_counts();
      ip_done_after = 0;
      hold0 = 8'h77;
      req0_data = hold0;
      req0_valid = 1'b1;
      #1;
      chk("rst_case_ready", 64'(req0_ready), 64'd1);
      t = cyc;
      step();
      req0_valid = 1'b0;
      step();
      step();
      chk("rst_case_in_chk", 64'(cyc - t), 64'd3);
      I_RESETN = 1'b1;
      step();
      chk("rst_mid_outputs", all_outs(), 64'd0);
      I_RESETN = 1'b0;
      model_last = 1'b1;
      pending = 2'b00;
      for (int i = 0; i < 8; i++) step();
      chk("rst_no_rsp", 64'(rsp_cnt), 64'd0);
      chk("rst_tx_count", 64'(tx_cnt), 64'd1);
      chk("rst_status_reads", 64'(stat_reads), 64'd1);
      hold0 = 8'h5C;
      run_one(2'b01, 1, 8'h81);

      // req1 twice back to back, then both valid: req0 wins
      hold1 = 8'h0F;
      run_one(2'b10, 1, 8'h21);
      hold1 = 8'hF0;
      run_one(2'b10, 2, 8'h43);
      hold0 = 8'h99;
      hold1 = 8'h66;
      run_one(2'b11, 1, 8'h65);
      run_one(pending, 1, 8'h87);

      // randomized traffic
      for (int n = 0; n < 12; n++) begin
         m = pending | 2'($urandom_range(1, 3));
         if (m[0] && !pending[0]) hold0 = 8'($urandom);
         if (m[1] && !pending[1]) hold1 = 8'($urandom);
         run_one(m, $urandom_range(0, PM), 8'($urandom));
      end
      if (pending != 2'b00) run_one(pending, $urandom_range(1, PM), 8'($urandom));

      chk("idle_value_rules", 64'(viol), 64'd0);

      // final report
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
